// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch stage: buffer entry layout, FSM
// states and the fetch-address legality check.
package fetch_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // 33-bit compare so a PC near 2^32 cannot wrap into a legal range.
    function automatic logic pc_legal(input logic [XLEN-1:0] pc,
                                      input logic [XLEN:0]   limit);
        return (pc[1:0] == 2'b00) &&
               (({1'b0, pc} + (XLEN+1)'(INSTR_BYTES)) <= limit);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO holding fetched {pc, instr} entries; flush empties it
// in one edge and overrides any push/pop on that edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic                          flush_i,
    input  fetch_entry_t                  wdata_i,
    output fetch_entry_t                  head_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && !empty_o;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/fetch_unit.sv
// PC generation and fetch stage: drives instr_mem, buffers {pc, instr} for
// decode, handles redirects and faults on illegal fetch addresses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 28,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic        fetch_fault
);
    localparam logic [XLEN:0] LIMIT = (XLEN+1)'(IMEM_BYTES);

    fetch_state_t                state_q, state_d;
    logic [XLEN-1:0]             pc_q, pc_d;
    logic                        push, pop;
    fetch_entry_t                head, wentry;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        full, empty;

    assign imem_addr   = pc_q;
    assign fetch_fault = (state_q == FAULT);
    assign dec_valid   = (count != '0);
    assign dec_pc      = empty ? '0 : head.pc;
    assign dec_instr   = empty ? '0 : head.instr;
    assign pop         = dec_valid && dec_ready;
    assign wentry      = '{pc: pc_q, instr: imem_instr};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = pc_legal(redirect_pc, LIMIT) ? RUN : FAULT;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!pc_legal(pc_q, LIMIT)) begin
                        state_d = FAULT;
                    end else if (fetch_en && (!full || pop)) begin
                        push = 1'b1;
                        pc_d = pc_q + XLEN'(INSTR_BYTES);
                    end
                end
                FAULT: ;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wentry),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a 7-word instruction memory.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog [0:7];

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd28 && imem_addr[1:0] == 2'b00) ?
                        prog[imem_addr[4:2]] : 32'h0;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(28), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .fetch_fault    (fetch_fault)
    );

    typedef struct {
        logic        fe, rdy, rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc, ei;
        logic        ef;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        fetch_en       = fe;
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] p,
                           input logic [31:0] ins, input logic f, input logic [31:0] a);
        chk({tag, ".valid"}, 32'(dec_valid), 32'(v));
        chk({tag, ".pc"},    dec_pc, p);
        chk({tag, ".instr"}, dec_instr, ins);
        chk({tag, ".fault"}, 32'(fetch_fault), 32'(f));
        chk({tag, ".addr"},  imem_addr, a);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        prog[0] = 32'h0090_0493; prog[1] = 32'h0050_0293; prog[2] = 32'h0062_A023;
        prog[3] = 32'hFFC4_A303; prog[4] = 32'h0012_8293; prog[5] = 32'hFE03_18E3;
        prog[6] = 32'hFE42_0AE3; prog[7] = 32'h0;

        // fe rdy rv rpc | valid pc instr fault addr
        tbl[0]  = '{1,1,0,0,  1, 0,  prog[0], 0, 4};
        tbl[1]  = '{1,1,0,0,  1, 4,  prog[1], 0, 8};
        tbl[2]  = '{1,1,0,0,  1, 8,  prog[2], 0, 12};
        tbl[3]  = '{1,1,0,0,  1, 12, prog[3], 0, 16};
        tbl[4]  = '{1,1,0,0,  1, 16, prog[4], 0, 20};
        tbl[5]  = '{1,1,0,0,  1, 20, prog[5], 0, 24};
        tbl[6]  = '{1,1,0,0,  1, 24, prog[6], 0, 28};
        tbl[7]  = '{1,1,0,0,  0, 0,  0,       1, 28};
        tbl[8]  = '{1,1,1,0,  0, 0,  0,       0, 0};
        tbl[9]  = '{1,1,0,0,  1, 0,  prog[0], 0, 4};
        tbl[10] = '{1,0,0,0,  1, 0,  prog[0], 0, 8};
        tbl[11] = '{1,0,0,0,  1, 0,  prog[0], 0, 8};
        tbl[12] = '{0,1,0,0,  1, 4,  prog[1], 0, 8};
        tbl[13] = '{0,1,0,0,  0, 0,  0,       0, 8};
        tbl[14] = '{1,1,1,6,  0, 0,  0,       1, 6};
        tbl[15] = '{1,1,0,0,  0, 0,  0,       1, 6};
        tbl[16] = '{1,1,1,4,  0, 0,  0,       0, 4};
        tbl[17] = '{1,1,0,0,  1, 4,  prog[1], 0, 8};
        tbl[18] = '{1,1,0,0,  1, 8,  prog[2], 0, 12};

        // Reset state and table run
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].fe, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ei, tbl[i].ef, tbl[i].ea);
        end

        // Backpressure from reset: buffer fills with 0,4 then drains in order
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("stall%0d.pc", c), dec_pc, 32'h0);
            chk($sformatf("stall%0d.addr", c), imem_addr, (c == 0) ? 32'd4 : 32'd8);
        end
        dec_ready = 1'b1;
        step();
        chk("release0.pc", dec_pc, 32'd4);
        chk("release0.addr", imem_addr, 32'd12);
        step();
        chk("release1.pc", dec_pc, 32'd8);

        // Redirect while buffer holds 20,24
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 6; c++) step();
        chk("pre_redir.pc", dec_pc, 32'd20);
        dec_ready = 1'b0;
        step();
        chk("pre_redir.addr", imem_addr, 32'd28);
        drive(1'b1, 1'b0, 1'b1, 32'd12);
        step();
        chk("redir.valid", 32'(dec_valid), 32'd0);
        chk("redir.addr", imem_addr, 32'd12);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        chk_out("redir_first", 1'b1, 32'd12, prog[3], 1'b0, 32'd16);

        // Async reset mid-stream with a full buffer
        dec_ready = 1'b0;
        step();
        step();
        chk("full.valid", 32'(dec_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        rst_n = 1'b1;
        dec_ready = 1'b1;
        step();
        chk_out("after_rst", 1'b1, 32'h0, prog[0], 1'b0, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
